// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with N-source writeback select and a 64-bit retired-instruction counter.
// Optional load lane extraction on source MEM_SRC is enabled by defining WB_LOAD_EXT_EN.
module writeback_stage #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 4,
    parameter int MEM_SRC = 1,
    parameter int RA_W    = 5,
    localparam int SEL_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall_w,
    input  logic                    flush_w,
    input  logic                    valid_m,
    input  logic                    reg_write_m,
    input  logic [RA_W-1:0]         rd_m,
    input  logic [SEL_W-1:0]        result_src_m,
    input  logic [NUM_SRC*XLEN-1:0] src_data_m,
    input  logic [1:0]              load_size_m,
    input  logic                    load_unsigned_m,
    input  logic [1:0]              addr_lo_m,
    output logic                    valid_w,
    output logic                    reg_write_w,
    output logic [RA_W-1:0]         rd_w,
    output logic [XLEN-1:0]         wb_result_w,
    output logic [63:0]             instret_w
);

    logic [SEL_W-1:0]        sel_q;
    logic [NUM_SRC*XLEN-1:0] src_q;
    logic [XLEN-1:0]         mem_raw;
    logic [XLEN-1:0]         mem_val;

    // Flush only clears control; the data registers keep their contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_w     <= 1'b0;
            reg_write_w <= 1'b0;
            rd_w        <= '0;
            sel_q       <= '0;
            src_q       <= '0;
            instret_w   <= '0;
        end else if (flush_w) begin
            valid_w     <= 1'b0;
            reg_write_w <= 1'b0;
            rd_w        <= '0;
        end else if (!stall_w) begin
            valid_w     <= valid_m;
            reg_write_w <= reg_write_m & valid_m & (rd_m != '0);
            rd_w        <= rd_m;
            sel_q       <= result_src_m;
            src_q       <= src_data_m;
            if (valid_m) begin
                instret_w <= instret_w + 64'd1;
            end
        end
    end

    assign mem_raw = src_q[MEM_SRC*XLEN +: XLEN];

`ifdef WB_LOAD_EXT_EN
    logic [1:0] size_q;
    logic       uns_q;
    logic [1:0] addr_lo_q;
    logic [7:0] lane_b;
    logic [15:0] lane_h;

    always_ff @(posedge clk) begin
        if (reset) begin
            size_q    <= '0;
            uns_q     <= 1'b0;
            addr_lo_q <= '0;
        end else if (!flush_w && !stall_w) begin
            size_q    <= load_size_m;
            uns_q     <= load_unsigned_m;
            addr_lo_q <= addr_lo_m;
        end
    end

    always_comb begin
        lane_b = mem_raw[{addr_lo_q, 3'b000} +: 8];
        lane_h = mem_raw[{addr_lo_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   mem_val = {{(XLEN-8){~uns_q & lane_b[7]}}, lane_b};
            2'b01:   mem_val = {{(XLEN-16){~uns_q & lane_h[15]}}, lane_h};
            default: mem_val = mem_raw;
        endcase
    end
`else
    logic unused_load;
    assign unused_load = ^{load_size_m, load_unsigned_m, addr_lo_m};
    assign mem_val     = mem_raw;
`endif

    // Out-of-range selects fall back to source 0.
    always_comb begin
        logic [XLEN-1:0] srcs [NUM_SRC];
        for (int i = 0; i < NUM_SRC; i++) begin
            srcs[i] = (i == MEM_SRC) ? mem_val : src_q[i*XLEN +: XLEN];
        end
        wb_result_w = srcs[0];
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel_q == SEL_W'(i)) begin
                wb_result_w = srcs[i];
            end
        end
    end

endmodule
